vector_dmem_responder: RTL and testbench
========================================

Name: vector_dmem_responder

Overview:
- Responder end of the Memory-stage data-memory interface for the 256-bit SIMD pipeline.
- Accepts one 256-bit vector load or store request per valid/ready handshake.
- Serializes the request into 8 word-wide (32-bit) beats against an internal word-addressed RAM.
- Returns one response (read data or write ack) on a valid/ready response channel; one transaction in flight at a time.

Parameters:
- DATA_W, 256, vector width; must equal LANES*WORD_W.
- WORD_W, 32, backing RAM word width.
- LANES, 8, beats per vector.
- ADDR_W, 32, byte address width.
- MEM_DEPTH, 1024, RAM depth in WORD_W words.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address of vector.
- req_wdata  in  DATA_W  store data; lane i = bits [32i+31:32i].
- req_lane_mask  in  LANES  per-lane store enable; see Optional Feature.
- resp_valid  out  1  response present.
- resp_ready  in  1  initiator accepts response.
- resp_rdata  out  DATA_W  load data (0 for stores and errors).
- resp_err  out  1  misaligned or out-of-range request.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE, beat counter=0, resp_valid=0, resp_err=0, resp_rdata=0, busy=0. RAM contents are not cleared.
- Reset mid-transaction aborts it. Lanes already stored stay written; no response is issued.
- States: IDLE, WRITE, READ, RESP.
- req_ready = (state==IDLE). It is combinational from state only and never depends on req_valid.
- Accept happens on an edge where req_valid && req_ready. At that edge the block latches req_we, the word base = req_addr[ADDR_W-1:2], req_wdata and the mask.
- Error check at accept:
  - Misaligned: req_addr[4:0] != 0.
  - Out-of-range: base+LANES-1 >= MEM_DEPTH.
  - On error: go to RESP at the accept edge with resp_err=1 and resp_rdata=0. No RAM access.
- WRITE: on each of the next LANES edges (beat k=0..7), mem[base+k] <= wdata lane k if its lane is enabled. After the edge that handles beat 7, go to RESP with resp_rdata=0 and resp_err=0.
- READ: on each of the next LANES edges, assembly lane k <= mem[base+k]. After beat 7, go to RESP; resp_rdata is the assembled vector.
- Latency: resp_valid rises 8 cycles after the accept edge for a good request, and 0 cycles after it (next cycle) for an error.
- RESP: resp_valid=1. resp_rdata and resp_err are held stable until an edge with resp_ready=1, then go to IDLE with resp_valid=0. resp_rdata keeps its last value.
- No overlap: a new request can be accepted at the earliest 1 cycle after the response handshake.
- Counter: 3-bit beat counter, cleared on accept. The beat counter never exceeds LANES-1; there is no wrap in RAM addressing because range is checked up front.
- Read-after-write: a load issued after a store's response sees the stored data.

Optional Feature:
- Macro: VDMEM_LANE_MASK_EN.
- Defined: a store writes lane k only if req_lane_mask[k]==1. Disabled lanes leave RAM unchanged but still take their beat cycle, so latency stays 8. A mask of 0 still gets a normal ack.
- Undefined: req_lane_mask is ignored and all 8 lanes are written.

Test Plan:
- Store addr=0x40, wdata lanes 0..7 = 0x11111111*(k+1), then load 0x40 -> store ack after 8 cycles (resp_err=0, resp_rdata=0); load resp_rdata lane k = 0x11111111*(k+1), resp_valid exactly 8 cycles after accept.
- Load addr=0x44 -> resp_valid the next cycle with resp_err=1, resp_rdata=0; a load of 0x40 afterwards returns the prior data, proving no RAM access.
- Load addr=0x1000 (word base 1024 >= MEM_DEPTH) -> resp_err=1 and RAM untouched; load addr=0xFE0 (base 1016, last legal vector) -> resp_err=0.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid -> resp_valid and resp_rdata stable and req_ready=0 throughout; release -> IDLE and req_ready=1 the next cycle.
- Reset mid-store: drive rst=0 after beat 3 of a store of 0xAAAAAAAA to all lanes at 0x80 (over prior zeros) -> outputs go to reset values and no response; reading 0x80 gives lanes 0..3 = 0xAAAAAAAA and lanes 4..7 = 0.
- With VDMEM_LANE_MASK_EN: store mask 8'b10100101 of all-0xFFFFFFFF over zeros, then load -> lanes 0,2,5,7 = 0xFFFFFFFF and the rest 0. Without the macro, all lanes = 0xFFFFFFFF.

Source files
------------

// File: rtl/vector_dmem_responder.sv
// rtl/vector_dmem_responder.sv - 256-bit vector load/store responder serializing into 8 word beats on a word RAM.
// Optional per-lane store enable: define VDMEM_LANE_MASK_EN.
module vector_dmem_responder #(
    parameter int DATA_W    = 256,
    parameter int WORD_W    = 32,
    parameter int LANES     = 8,
    parameter int ADDR_W    = 32,
    parameter int MEM_DEPTH = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [LANES-1:0]  req_lane_mask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    localparam int RAM_AW  = $clog2(MEM_DEPTH);
    localparam int BEAT_W  = $clog2(LANES);
    localparam int ALIGN_W = $clog2(DATA_W / 8);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BEAT_W-1:0]   r_beat;
    logic [RAM_AW-1:0]   r_base;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic [WORD_W-1:0]   r_mem [MEM_DEPTH];

    logic                w_accept;
    logic                w_misaligned;
    logic [ADDR_W-1:0]   w_last_word;
    logic                w_out_of_range;
    logic                w_req_err;
    logic                w_last_beat;
    logic                w_lane_en;
    logic [RAM_AW-1:0]   w_ram_addr;
    logic [WORD_W-1:0]   w_wr_word;
    logic [WORD_W-1:0]   w_rd_word;

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign busy       = (r_state != S_IDLE);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    // Range is checked on the last word of the vector so no beat can run off the RAM.
    assign w_accept       = req_valid && req_ready;
    assign w_misaligned   = |req_addr[ALIGN_W-1:0];
    assign w_last_word    = {2'b00, req_addr[ADDR_W-1:2]} + ADDR_W'(LANES - 1);
    assign w_out_of_range = (w_last_word >= ADDR_W'(MEM_DEPTH));
    assign w_req_err      = w_misaligned || w_out_of_range;
    assign w_last_beat    = (r_beat == BEAT_W'(LANES - 1));

    assign w_ram_addr = r_base + RAM_AW'(r_beat);
    assign w_wr_word  = r_wdata[int'(r_beat) * WORD_W +: WORD_W];
    assign w_rd_word  = r_mem[w_ram_addr];

`ifdef VDMEM_LANE_MASK_EN
    logic [LANES-1:0] r_mask;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mask <= req_lane_mask;
        end
    end

    assign w_lane_en = r_mask[r_beat];
`else
    assign w_lane_en = (&req_lane_mask) | 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_req_err) begin
                        w_state_nxt = S_RESP;
                    end else if (req_we) begin
                        w_state_nxt = S_WRITE;
                    end else begin
                        w_state_nxt = S_READ;
                    end
                end
            end
            S_WRITE, S_READ: begin
                if (w_last_beat) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_base  <= req_addr[RAM_AW+1:2];
            r_wdata <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_beat  <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else if (w_accept) begin
            r_beat  <= '0;
            r_err   <= w_req_err;
            r_rdata <= '0;
        end else if (r_state == S_WRITE || r_state == S_READ) begin
            if (!w_last_beat) begin
                r_beat <= r_beat + 1'b1;
            end
            if (r_state == S_READ) begin
                r_rdata[int'(r_beat) * WORD_W +: WORD_W] <= w_rd_word;
            end
        end
    end

    // A reset landing on a write beat must not commit that beat.
    always_ff @(posedge clk) begin
        if (rst && r_state == S_WRITE && w_lane_en) begin
            r_mem[w_ram_addr] <= w_wr_word;
        end
    end

endmodule

// File: tb/tb_vector_dmem_responder.sv
// tb/tb_vector_dmem_responder.sv - scoreboard bench for vector_dmem_responder.
module tb_vector_dmem_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [31:0]  req_addr;
    logic [255:0] req_wdata;
    logic [7:0]   req_lane_mask;
    logic         resp_valid;
    logic         resp_ready;
    logic [255:0] resp_rdata;
    logic         resp_err;
    logic         busy;

    typedef struct {
        logic [255:0] rdata;
        logic         err;
        int           lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_mem [1024];
    int          n_checks = 0;
    int          n_errors = 0;

    vector_dmem_responder dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_lane_mask(req_lane_mask),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic lane_on(input logic [7:0] mask, input int k);
`ifdef VDMEM_LANE_MASK_EN
        return mask[k];
`else
        return mask[k] | 1'b1;
`endif
    endfunction

    function automatic logic [255:0] splat(input logic [31:0] w);
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = w;
        return v;
    endfunction

    task automatic send(input logic we, input logic [31:0] addr, input logic [255:0] wdata,
                        input logic [7:0] mask, input int hold);
        exp_t e;
        int   cyc;
        longint base;
        base  = longint'(addr >> 2);
        e.err = (addr[4:0] != 5'd0) || (base + 7 >= 1024);
        e.rdata = '0;
        e.lat = e.err ? 0 : 8;
        if (!e.err) begin
            for (int k = 0; k < 8; k++) begin
                if (we) begin
                    if (lane_on(mask, k)) m_mem[int'(base) + k] = wdata[k*32 +: 32];
                end else begin
                    e.rdata[k*32 +: 32] = m_mem[int'(base) + k];
                end
            end
        end
        sb.push_back(e);
        check("req_ready_idle", req_ready, 1);
        req_valid     = 1'b1;
        req_we        = we;
        req_addr      = addr;
        req_wdata     = wdata;
        req_lane_mask = mask;
        resp_ready    = (hold == 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 0;
        while (!resp_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        e = sb.pop_front();
        check("resp_valid", resp_valid, 1);
        check("latency", cyc, e.lat);
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", resp_err, e.err);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("bp_valid", resp_valid, 1);
            check("bp_rdata", resp_rdata, e.rdata);
            check("bp_req_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("post_valid", resp_valid, 0);
        check("post_req_ready", req_ready, 1);
    endtask

    initial begin
        logic [255:0] pat;
        logic [255:0] rnd;
        logic [31:0]  a;

        rst           = 1'b0;
        req_valid     = 1'b0;
        req_we        = 1'b0;
        req_addr      = '0;
        req_wdata     = '0;
        req_lane_mask = 8'hFF;
        resp_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 1);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 8; k++) pat[k*32 +: 32] = 32'h11111111 * (k + 1);
        send(1'b1, 32'h40, pat, 8'hFF, 0);
        send(1'b0, 32'h40, '0, 8'hFF, 0);

        send(1'b0, 32'h44, '0, 8'hFF, 0);
        send(1'b1, 32'h44, {256{1'b1}}, 8'hFF, 0);
        send(1'b0, 32'h40, '0, 8'hFF, 0);

        send(1'b0, 32'h1000, '0, 8'hFF, 0);
        for (int k = 0; k < 8; k++) rnd[k*32 +: 32] = $urandom;
        send(1'b1, 32'hFE0, rnd, 8'hFF, 0);
        send(1'b0, 32'hFE0, '0, 8'hFF, 0);

        send(1'b0, 32'h40, '0, 8'hFF, 5);

        // Abort a store after four beats; only those lanes may land.
        send(1'b1, 32'h80, '0, 8'hFF, 0);
        check("mid_req_ready", req_ready, 1);
        req_valid     = 1'b1;
        req_we        = 1'b1;
        req_addr      = 32'h80;
        req_wdata     = splat(32'hAAAAAAAA);
        req_lane_mask = 8'hFF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_valid", resp_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_err", resp_err, 0);
        check("mid_rst_rdata", resp_rdata, 0);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) m_mem[32 + k] = 32'hAAAAAAAA;
        @(posedge clk); #1;
        check("mid_no_resp", resp_valid, 0);
        send(1'b0, 32'h80, '0, 8'hFF, 0);

        send(1'b1, 32'h100, '0, 8'hFF, 0);
        send(1'b1, 32'h100, {256{1'b1}}, 8'b10100101, 0);
        send(1'b0, 32'h100, '0, 8'hFF, 0);

        for (int t = 0; t < 4; t++) begin
            a = ($urandom % 127) * 32;
            for (int k = 0; k < 8; k++) rnd[k*32 +: 32] = $urandom;
            send(1'b1, a, '0, 8'hFF, 0);
            send(1'b1, a, rnd, 8'($urandom), 0);
            send(1'b0, a, '0, 8'hFF, t % 2);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
